dmem_responder: RTL and testbench

Data-memory responder that services load/store requests issued by the CPU's Memory stage over a valid/ready request channel. It returns a one-cycle response pulse after a programmable number of wait states. It holds a word-organised RAM with byte-lane writes and sign/zero-extending sub-word reads. It is the target end of the data-memory interface, replacing the zero-latency array once the pipeline gains stall support.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_lane_align.sv | 45 ++++
 rtl/dmem_responder.sv | 164 ++++++++++++++++
 tb/tb_dmem_responder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: size codes, FSM states,
// and the wait-state counter width.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_X = 2'd3;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store data replication and lane enables,
// plus shift-down and sign/zero extension of sub-word loads.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  always_comb begin
    be_o    = '0;
    wdata_o = '0;
    rdata_o = '0;
    shifted = rword_i >> {addr_lo_i, 3'b000};
    case (size_i)
      SZ_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = unsigned_i ? {24'h0, shifted[7:0]}
                             : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        be_o    = 4'b0011 << addr_lo_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = unsigned_i ? {16'h0, shifted[15:0]}
                             : {{16{shifted[15]}}, shifted[15:0]};
      end
      SZ_W: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rword_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request channel, programmable wait
// states, word RAM with byte-lane writes and a one-cycle response pulse.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DAT_WIDTH   = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DAT_WIDTH-1:0]  req_wdata,
  output logic                  rsp_valid,
  output logic [DAT_WIDTH-1:0]  rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_WIDTH-2:0] DEPTH_EXT = (ADDR_WIDTH-1)'(DEPTH_WORDS);

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    ready_q;
  logic                    rsp_valid_q;
  logic [DAT_WIDTH-1:0]    rsp_rdata_q;
  logic                    rsp_err_q;
  logic                    write_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [1:0]              size_q;
  logic                    uns_q;
  logic [DAT_WIDTH-1:0]    wdata_q;
  logic [DAT_WIDTH-1:0]    rword_q;

  logic [DAT_WIDTH-1:0]    mem [DEPTH_WORDS];

  logic                    accept;
  logic                    commit;
  logic                    cur_write;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [1:0]              cur_size;
  logic                    cur_uns;
  logic [DAT_WIDTH-1:0]    cur_wdata;
  logic                    cur_err;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              be;
  logic [DAT_WIDTH-1:0]    st_data;
  logic [DAT_WIDTH-1:0]    ld_data;

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  assign accept = req_valid && ready_q;

  // With zero wait states the commit edge is the accept edge, so in IDLE the
  // live request fields stand in for the not-yet-captured registers.
  always_comb begin
    cur_write = write_q;
    cur_addr  = addr_q;
    cur_size  = size_q;
    cur_uns   = uns_q;
    cur_wdata = wdata_q;
    if (state_q == IDLE) begin
      cur_write = req_write;
      cur_addr  = req_addr;
      cur_size  = req_size;
      cur_uns   = req_unsigned;
      cur_wdata = req_wdata;
    end
  end

  always_comb begin
    cur_err = (cur_size == SZ_X)
           || (cur_size == SZ_H && cur_addr[0])
           || (cur_size == SZ_W && cur_addr[1:0] != 2'b00)
           || ({1'b0, cur_addr[ADDR_WIDTH-1:2]} >= DEPTH_EXT);
    idx     = cur_addr[IDX_W+1:2];
  end

  assign commit = !rst && (((state_q == IDLE) && accept && (WAIT_CYCLES == 0))
                        || ((state_q == WAIT) && (cnt_q == '0)));

  dmem_lane_align u_align (
    .addr_lo_i  (cur_addr[1:0]),
    .size_i     (cur_size),
    .unsigned_i (cur_uns),
    .wdata_i    (cur_wdata),
    .rword_i    (rword_q),
    .be_o       (be),
    .wdata_o    (st_data),
    .rdata_o    (ld_data)
  );

  always_ff @(posedge clk) begin
    if (commit && !cur_err) begin
      if (cur_write) begin
        for (int unsigned l = 0; l < 4; l++) begin
          if (be[l]) mem[idx][8*l +: 8] <= st_data[8*l +: 8];
        end
      end
      rword_q <= mem[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
            ready_q <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              state_q <= WAIT;
              cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
            end else begin
              state_q <= RESP;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= RESP;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        RESP: begin
          state_q     <= IDLE;
          ready_q     <= 1'b1;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= cur_err;
          rsp_rdata_q <= (cur_err || write_q) ? '0 : ld_data;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with two wait states, one with none,
// checked against a byte-addressed behavioural memory model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_a = 1'b0;
  logic        valid_b = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;

  logic        ready_a, rsp_valid_a, err_a;
  logic [31:0] rdata_a;
  logic        ready_b, rsp_valid_b, err_b;
  logic [31:0] rdata_b;

  byte unsigned mem_a[int unsigned];
  byte unsigned mem_b[int unsigned];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_WIDTH(32), .DAT_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)
  ) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(valid_a), .req_ready(ready_a),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rdata_a), .rsp_err(err_a)
  );

  dmem_responder #(
    .ADDR_WIDTH(32), .DAT_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)
  ) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(valid_b), .req_ready(ready_b),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rdata_b), .rsp_err(err_b)
  );

  function automatic logic [7:0] m_rd(bit which, int unsigned a);
    if (which) return mem_b.exists(a) ? mem_b[a] : 8'h00;
    return mem_a.exists(a) ? mem_a[a] : 8'h00;
  endfunction

  // Memory viewed as bytes; a load gathers little-endian bytes and extends.
  task automatic model_txn(input bit which, input bit w, input logic [31:0] a,
                           input logic [1:0] s, input bit u, input logic [31:0] wd,
                           output logic [31:0] ed, output bit ee);
    int unsigned n;
    longint unsigned v;
    ee = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00)
      || ((a >> 2) >= DEPTH);
    ed = '0;
    if (!ee) begin
      n = 1 << s;
      if (w) begin
        for (int unsigned i = 0; i < n; i++) begin
          if (which) mem_b[a + i] = wd[8*i +: 8];
          else       mem_a[a + i] = wd[8*i +: 8];
        end
      end else begin
        v = 0;
        for (int unsigned i = 0; i < n; i++)
          v = v | (longint'(m_rd(which, a + i)) << (8*i));
        if (!u && n < 4 && v[8*n-1]) v = v | (64'hFFFF_FFFF << (8*n));
        ed = v[31:0];
      end
    end
  endtask

  task automatic do_txn(input bit which, input bit w, input logic [31:0] a,
                        input logic [1:0] s, input bit u, input logic [31:0] wd,
                        output logic [31:0] rd, output bit er, output int lat);
    int guard;
    @(negedge clk);
    req_write = w; req_addr = a; req_size = s; req_unsigned = u; req_wdata = wd;
    if (which) valid_b = 1'b1; else valid_a = 1'b1;
    guard = 0;
    while (!(which ? ready_b : ready_a) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
    lat = 0;
    while (!(which ? rsp_valid_b : rsp_valid_a) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = which ? rdata_b : rdata_a;
    er = which ? err_b : err_a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({ready_a, rsp_valid_a, rdata_a, err_a} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
        $display("FAIL reset_idle_a cyc=%0d got rdy=%b v=%b d=%h e=%b want 1 0 0 0",
                 i, ready_a, rsp_valid_a, rdata_a, err_a);
      end else n_pass++;
      n_checks++;
      if ({ready_b, rsp_valid_b, rdata_b, err_b} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
        $display("FAIL reset_idle_b cyc=%0d got rdy=%b v=%b d=%h e=%b want 1 0 0 0",
                 i, ready_b, rsp_valid_b, rdata_b, err_b);
      end else n_pass++;
    end
  endtask

  task automatic preclear();
    logic [31:0] rd, ed;
    bit er, ee;
    int lat;
    for (int unsigned w = 0; w < 32; w++) begin
      for (int unsigned k = 0; k < 2; k++) begin
        model_txn(k[0], 1'b1, 32'(w*4), 2'd2, 1'b0, 32'h0, ed, ee);
        do_txn(k[0], 1'b1, 32'(w*4), 2'd2, 1'b0, 32'h0, rd, er, lat);
      end
    end
  endtask

  task automatic test_word_latency();
    logic [31:0] rd, ed;
    bit er, ee;
    int lat;
    model_txn(1'b0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, ed, ee);
    do_txn(1'b0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, rd, er, lat);
    n_checks++;
    if (lat !== 3 || er !== 1'b0 || rd !== 32'h0) begin
      $display("FAIL store_word got lat=%0d err=%b d=%h want lat=3 err=0 d=0", lat, er, rd);
    end else n_pass++;
    model_txn(1'b0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, ed, ee);
    do_txn(1'b0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, rd, er, lat);
    n_checks++;
    if (lat !== 3 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      $display("FAIL load_word got lat=%0d err=%b d=%h want lat=3 err=0 d=deadbeef", lat, er, rd);
    end else n_pass++;
    @(negedge clk);
    n_checks++;
    if (rsp_valid_a !== 1'b0 || rdata_a !== 32'hDEADBEEF) begin
      $display("FAIL rsp_pulse_hold got v=%b d=%h want v=0 d=deadbeef", rsp_valid_a, rdata_a);
    end else n_pass++;
  endtask

  task automatic test_subword();
    logic [31:0] rd, ed;
    bit er, ee;
    int lat;
    logic [31:0] exp_tab [3] = '{32'hFFFFFF80, 32'h00000080, 32'h00008000};
    logic [31:0] adr_tab [3] = '{32'h21, 32'h21, 32'h20};
    logic [1:0]  sz_tab  [3] = '{2'd0, 2'd0, 2'd2};
    bit          un_tab  [3] = '{1'b0, 1'b1, 1'b0};
    model_txn(1'b0, 1'b1, 32'h21, 2'd0, 1'b0, 32'h80, ed, ee);
    do_txn(1'b0, 1'b1, 32'h21, 2'd0, 1'b0, 32'h80, rd, er, lat);
    for (int i = 0; i < 3; i++) begin
      model_txn(1'b0, 1'b0, adr_tab[i], sz_tab[i], un_tab[i], 32'h0, ed, ee);
      do_txn(1'b0, 1'b0, adr_tab[i], sz_tab[i], un_tab[i], 32'h0, rd, er, lat);
      n_checks++;
      if (rd !== exp_tab[i] || er !== 1'b0) begin
        $display("FAIL subword_load%0d got d=%h err=%b want d=%h err=0", i, rd, er, exp_tab[i]);
      end else n_pass++;
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, ed;
    bit er, ee;
    int lat;
    do_txn(1'b0, 1'b0, 32'h13, 2'd1, 1'b0, 32'h0, rd, er, lat);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      $display("FAIL misaligned_half got err=%b d=%h want err=1 d=0", er, rd);
    end else n_pass++;
    do_txn(1'b0, 1'b0, 32'h8, 2'd3, 1'b0, 32'h0, rd, er, lat);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      $display("FAIL size3 got err=%b d=%h want err=1 d=0", er, rd);
    end else n_pass++;
    do_txn(1'b0, 1'b1, DEPTH*4, 2'd2, 1'b0, 32'hCAFEF00D, rd, er, lat);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      $display("FAIL out_of_range_store got err=%b d=%h want err=1 d=0", er, rd);
    end else n_pass++;
    model_txn(1'b0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, ed, ee);
    do_txn(1'b0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== ed || er !== 1'b0) begin
      $display("FAIL oor_no_alias got d=%h err=%b want d=%h err=0", rd, er, ed);
    end else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, ed, a;
    bit er, ee, seen;
    int lat, guard;
    for (int d = 0; d < 2; d++) begin
      a = 32'h40 + 32'(d*4);
      @(negedge clk);
      req_write = 1'b1; req_addr = a; req_size = 2'd2; req_unsigned = 1'b0;
      req_wdata = 32'h12345678;
      valid_a = 1'b1;
      guard = 0;
      while (!ready_a && guard < 20) begin @(negedge clk); guard++; end
      @(posedge clk);
      @(negedge clk);
      valid_a = 1'b0;
      repeat (d) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (ready_a !== 1'b1 || rsp_valid_a !== 1'b0) begin
        $display("FAIL reset_mid_idle d=%0d got rdy=%b v=%b want rdy=1 v=0", d, ready_a, rsp_valid_a);
      end else n_pass++;
      seen = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (rsp_valid_a) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0) begin
        $display("FAIL reset_mid_no_rsp d=%0d got rsp seen=%b want 0", d, seen);
      end else n_pass++;
      model_txn(1'b0, 1'b0, a, 2'd2, 1'b0, 32'h0, ed, ee);
      do_txn(1'b0, 1'b0, a, 2'd2, 1'b0, 32'h0, rd, er, lat);
      n_checks++;
      if (rd !== ed || er !== 1'b0) begin
        $display("FAIL reset_mid_no_write d=%0d got d=%h err=%b want d=%h err=0", d, rd, er, ed);
      end else n_pass++;
    end
  endtask

  task automatic rand_req(output bit w, output logic [31:0] a, output logic [1:0] s,
                          output bit u, output logic [31:0] wd);
    w  = $urandom_range(0, 1) == 1;
    s  = 2'($urandom_range(0, 3));
    u  = $urandom_range(0, 1) == 1;
    wd = $urandom;
    if ($urandom_range(0, 7) == 0) a = 32'h1000 + 32'($urandom_range(0, 255));
    else                           a = 32'($urandom_range(0, 127));
    if ($urandom_range(0, 3) != 0 && s != 2'd3)
      a = a & ~((32'h1 << s) - 32'h1);
  endtask

  task automatic test_random();
    logic [31:0] rd, ed, a, wd;
    logic [1:0] s;
    bit er, ee, w, u;
    int lat;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 40; i++) begin
        rand_req(w, a, s, u, wd);
        model_txn(k[0], w, a, s, u, wd, ed, ee);
        do_txn(k[0], w, a, s, u, wd, rd, er, lat);
        n_checks++;
        if (rd !== ed || er !== ee || lat !== (k == 1 ? 1 : 3)) begin
          $display("FAIL random dut=%0d i=%0d w=%b a=%h s=%0d u=%b got d=%h e=%b lat=%0d want d=%h e=%b",
                   k, i, w, a, s, u, rd, er, lat, ed, ee);
        end else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ed, a, wd;
    logic [1:0] s;
    bit ee, w, u, exp_rdy, exp_v;
    logic [31:0] q_d[$];
    bit q_e[$];
    logic [31:0] pd;
    bit pe;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      exp_rdy = (i % 2 == 0) || (i > 10);
      exp_v   = (i >= 2) && (i <= 10) && (i % 2 == 0);
      n_checks++;
      if (ready_b !== exp_rdy || rsp_valid_b !== exp_v) begin
        $display("FAIL b2b_handshake i=%0d got rdy=%b v=%b want rdy=%b v=%b",
                 i, ready_b, rsp_valid_b, exp_rdy, exp_v);
      end else n_pass++;
      if (exp_v && q_d.size() > 0) begin
        pd = q_d.pop_front();
        pe = q_e.pop_front();
        n_checks++;
        if (rdata_b !== pd || err_b !== pe) begin
          $display("FAIL b2b_data i=%0d got d=%h e=%b want d=%h e=%b", i, rdata_b, err_b, pd, pe);
        end else n_pass++;
      end
      if (i % 2 == 0 && i < 10) begin
        rand_req(w, a, s, u, wd);
        model_txn(1'b1, w, a, s, u, wd, ed, ee);
        q_d.push_back(ed);
        q_e.push_back(ee);
        req_write = w; req_addr = a; req_size = s; req_unsigned = u; req_wdata = wd;
        valid_b = 1'b1;
      end else if (i == 10) begin
        valid_b = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    preclear();
    test_word_latency();
    test_subword();
    test_errors();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
